// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared state encoding, default sizes and majority vote for serdes_stream_cipher
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    ENCRYPT = 2'd2,
    OUTPUT  = 2'd3
  } state_e;

  localparam int WORD_W_DEF = 8;
  localparam int KEY_W_DEF  = 128;

  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serdes_key_sched.sv
// rtl/serdes_key_sched.sv - rotating key slice selector; one slice per frame, wraps after KEY_W/WORD_W frames
module serdes_key_sched #(
  parameter int WORD_W = 8,
  parameter int KEY_W  = 128
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic [WORD_W-1:0] slice_o
);

  localparam int NSLICE = KEY_W / WORD_W;
  localparam int FI_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  logic [FI_W-1:0] frame_idx_q;
  logic [FI_W-1:0] frame_idx_d;

  always_comb begin
    frame_idx_d = frame_idx_q;
    if (clear_i) begin
      frame_idx_d = '0;
    end else if (advance_i) begin
      frame_idx_d = (frame_idx_q == FI_W'(NSLICE - 1)) ? '0 : frame_idx_q + FI_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    frame_idx_q <= frame_idx_d;
  end

  assign slice_o = key_i[frame_idx_q*WORD_W +: WORD_W];

endmodule

// File: rtl/serdes_stream_cipher.sv
// rtl/serdes_stream_cipher.sv - two serial streams XORed with a rotating key slice, serialised MSB first
// Optional majority-vote output smoothing: SERDES_MAJ_FILTER_EN
module serdes_stream_cipher
  import serdes_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int KEY_W  = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WORD_W + 1);

  state_e            state_q;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [WORD_W-1:0] word_q;
  logic [CW-1:0]     bit_cnt_q;
  logic              done_q;
  logic [WORD_W-1:0] key_slice;
  logic              last_cnt;
  logic              out_xfer;
  logic              cur;

  assign cur      = word_q[WORD_W-1];
  assign last_cnt = (bit_cnt_q == CW'(WORD_W - 1));
  assign out_xfer = (state_q == OUTPUT) && out_ready;

  serdes_key_sched #(
    .WORD_W (WORD_W),
    .KEY_W  (KEY_W)
  ) u_key_sched (
    .clk_i     (clk),
    .clear_i   (rst),
    .advance_i (out_xfer && last_cnt),
    .key_i     (key),
    .slice_o   (key_slice)
  );

`ifdef SERDES_MAJ_FILTER_EN
  logic [1:0] h_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
    end else if (state_q == ENCRYPT) begin
      h_q <= '0;
    end else if (out_xfer) begin
      h_q <= {h_q[0], cur};
    end
  end

  assign out_bit = majority3(cur, h_q[0], h_q[1]);
`else
  assign out_bit = cur;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      word_q    <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
          end
        end
        SHIFT: begin
          if (in_valid) begin
            a_q       <= {a_q[WORD_W-2:0], a_bit};
            b_q       <= {b_q[WORD_W-2:0], b_bit};
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (last_cnt) begin
              state_q <= ENCRYPT;
            end
          end
        end
        ENCRYPT: begin
          word_q    <= a_q ^ b_q ^ key_slice;
          bit_cnt_q <= '0;
          state_q   <= OUTPUT;
        end
        OUTPUT: begin
          // out_bit must stay frozen while the sink stalls, so word only moves on a transfer
          if (out_ready) begin
            word_q    <= {word_q[WORD_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (last_cnt) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == SHIFT);
  assign out_valid = (state_q == OUTPUT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_serdes_stream_cipher.sv
// tb/tb_serdes_stream_cipher.sv - directed bench for serdes_stream_cipher (WORD_W=8, KEY_W=128)
module tb_serdes_stream_cipher;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         a_bit = 1'b0;
  logic         b_bit = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_bit;
  logic         out_ready = 1'b1;
  logic         done;
  logic         busy;

  int tests = 0;
  int fails = 0;

  serdes_stream_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .start     (start),
    .in_valid  (in_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

`ifdef SERDES_MAJ_FILTER_EN
  localparam logic [7:0] EXP_C4 = 8'h60;
  localparam logic [7:0] EXP_12 = 8'h00;
  localparam logic [7:0] EXP_34 = 8'h1C;
  localparam logic [7:0] EXP_E2 = 8'h70;
`else
  localparam logic [7:0] EXP_C4 = 8'hC4;
  localparam logic [7:0] EXP_12 = 8'h12;
  localparam logic [7:0] EXP_34 = 8'h34;
  localparam logic [7:0] EXP_E2 = 8'hE2;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat = edges from the start-sampling edge until done is first seen high
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input bit vtoggle,
                           input int stall_at, input bit glitch,
                           output logic [7:0] res, output int lat);
    int n;
    int got;
    int stall;
    logic held;
    res = '0;
    lat = -1;
    n = 0;
    got = 0;
    stall = stall_at;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (vtoggle) begin
        in_valid = 1'b0;
        a_bit = ~a[7-i];
        b_bit = ~b[7-i];
        tick();
        n++;
      end
      in_valid = 1'b1;
      a_bit = a[7-i];
      b_bit = b[7-i];
      if (glitch && i == 3) start = 1'b1;
      tick();
      n++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    while (got < 8 && n < 100) begin
      out_ready = 1'b1;
      if (stall == got && out_valid) begin
        out_ready = 1'b0;
        held = out_bit;
        for (int s = 0; s < 5; s++) begin
          tick();
          n++;
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_out_bit", {31'd0, out_bit}, {31'd0, held});
        end
        stall = -1;
        out_ready = 1'b1;
      end
      if (glitch && got == 4) start = 1'b1;
      if (out_valid) begin
        res = {res[6:0], out_bit};
        got++;
      end
      tick();
      n++;
      start = 1'b0;
    end
    chk("frame_complete", got, 32'd8);
    if (done) lat = n;
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    tick();
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] res;
    int lat;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_bit", {31'd0, out_bit}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    run_frame(8'hFF, 8'h0F, 1'b0, -1, 1'b0, res, lat);
    chk("frame0_data", {24'd0, res}, {24'd0, EXP_C4});
    chk("frame0_done_latency", lat, 32'd17);

    run_frame(8'h00, 8'h00, 1'b0, -1, 1'b0, res, lat);
    chk("frame1_slice1", {24'd0, res}, {24'd0, EXP_12});

    for (int f = 2; f < 16; f++) begin
      run_frame(8'h00, 8'h00, 1'b0, -1, 1'b0, res, lat);
    end
    run_frame(8'h00, 8'h00, 1'b0, -1, 1'b0, res, lat);
    chk("frame16_wrap", {24'd0, res}, {24'd0, EXP_34});

    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_frame(8'hFF, 8'h0F, 1'b1, -1, 1'b0, res, lat);
    chk("in_valid_toggle_data", {24'd0, res}, {24'd0, EXP_C4});

    run_frame(8'hFF, 8'h0F, 1'b0, 3, 1'b0, res, lat);
    chk("out_stall_data", {24'd0, res}, {24'd0, EXP_E2});
    chk("out_stall_latency", lat, 32'd22);

    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b0;
    repeat (8) tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    tick();
    chk("rst_mid_no_done", {31'd0, done}, 32'd0);

    run_frame(8'h00, 8'h00, 1'b0, -1, 1'b0, res, lat);
    chk("after_rst_slice0", {24'd0, res}, {24'd0, EXP_34});

    run_frame(8'hFF, 8'h0F, 1'b0, -1, 1'b1, res, lat);
    chk("start_glitch_data", {24'd0, res}, {24'd0, EXP_E2});
    chk("start_glitch_latency", lat, 32'd17);
    chk("start_glitch_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
